// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - read-only direct-mapped instruction cache with line-wide fill
module icache_direct_mapped #(
   parameter int S_INDEX  = 3,
   parameter int S_OFFSET = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inst_read,
   input  logic [31:0]  inst_addr,
   output logic         inst_resp,
   output logic [31:0]  inst_rdata,
   output logic         pmem_read,
   output logic [31:0]  pmem_address,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
);
   localparam int TAG_W = 32 - S_OFFSET - S_INDEX;
   localparam int SETS  = 1 << S_INDEX;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                   state;
   logic [SETS-1:0]          valid;
   logic [TAG_W-1:0]         tag_arr [SETS];
   logic [255:0]             data_arr [SETS];
   logic [TAG_W+S_INDEX-1:0] fill_addr;

   logic [TAG_W-1:0]         req_tag;
   logic [S_INDEX-1:0]       req_idx;
   logic [2:0]               req_word;
   logic [TAG_W-1:0]         fill_tag;
   logic [S_INDEX-1:0]       fill_idx;
   logic                     hit;
   logic                     unused_addr_bits;

   assign req_tag          = inst_addr[31 -: TAG_W];
   assign req_idx          = inst_addr[S_OFFSET +: S_INDEX];
   assign req_word         = inst_addr[4:2];
   assign unused_addr_bits = ^inst_addr[1:0];
   assign fill_tag         = fill_addr[TAG_W+S_INDEX-1:S_INDEX];
   assign fill_idx         = fill_addr[S_INDEX-1:0];

   // Lookup is purely combinational so a hit answers in the request cycle.
   assign hit        = (state == IDLE) && inst_read && valid[req_idx]
                       && (tag_arr[req_idx] == req_tag);
   assign inst_resp  = hit;
   assign inst_rdata = data_arr[req_idx][{req_word, 5'b00000} +: 32];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         valid        <= '0;
         fill_addr    <= '0;
         pmem_read    <= 1'b0;
         pmem_address <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
      end else begin
         if (hit && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
         end
         case (state)
            IDLE: begin
               if (inst_read && !hit) begin
                  fill_addr    <= {req_tag, req_idx};
                  pmem_read    <= 1'b1;
                  pmem_address <= {req_tag, req_idx, {S_OFFSET{1'b0}}};
                  if (miss_count != 32'hFFFF_FFFF) begin
                     miss_count <= miss_count + 32'd1;
                  end
                  state        <= FILL;
               end
            end
            FILL: begin
               // The fill completes even if the requester has moved on.
               if (pmem_resp) begin
                  valid[fill_idx] <= 1'b1;
                  pmem_read       <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag/data arrays carry no reset; valid bits alone gate their use.
   always_ff @(posedge clk) begin
      if ((state == FILL) && pmem_resp) begin
         data_arr[fill_idx] <= pmem_rdata;
         tag_arr[fill_idx]  <= fill_tag;
      end
   end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - directed scoreboard bench for icache_direct_mapped
module tb_icache_direct_mapped;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         inst_read = 1'b0;
   logic [31:0]  inst_addr = '0;
   logic         inst_resp;
   logic [31:0]  inst_rdata;
   logic         pmem_read;
   logic [31:0]  pmem_address;
   logic [255:0] mem_rdata = '0;
   logic         mem_resp = 1'b0;
   logic         stray_resp = 1'b0;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   int           n_checks = 0;
   int           n_fail = 0;
   int           n_fills = 0;
   int           mem_cnt = 0;
   logic [31:0]  last_fill = '0;
   logic [31:0]  exp_q [$];

   icache_direct_mapped #(.S_INDEX(3), .S_OFFSET(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_read    (inst_read),
      .inst_addr    (inst_addr),
      .inst_resp    (inst_resp),
      .inst_rdata   (inst_rdata),
      .pmem_read    (pmem_read),
      .pmem_address (pmem_address),
      .pmem_rdata   (mem_rdata),
      .pmem_resp    (mem_resp | stray_resp),
      .hit_count    (hit_count),
      .miss_count   (miss_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if ({a[31:2], 2'b00} == 32'h6000_0004) return 32'h0000_0013;
      return {a[31:2], 2'b00} ^ 32'h5EED_0000;
   endfunction

   function automatic logic [255:0] make_line(input logic [31:0] base);
      logic [255:0] l;
      logic [2:0]   wv;
      l = '0;
      for (int w = 0; w < 8; w++) begin
         wv = w[2:0];
         l[32*w +: 32] = mem_word({base[31:5], wv, 2'b00});
      end
      return l;
   endfunction

   // Memory: answers a held pmem_read in its third cycle.
   always @(negedge clk) begin
      if (!pmem_read || mem_resp) begin
         mem_cnt  = 0;
         mem_resp = 1'b0;
      end else begin
         mem_cnt = mem_cnt + 1;
         if (mem_cnt == 3) begin
            mem_resp  = 1'b1;
            mem_rdata = make_line(pmem_address);
            last_fill = pmem_address;
            n_fills   = n_fills + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] a, input int exp_lat, input string tag);
      int          lat;
      logic [31:0] exp_word;
      @(negedge clk);
      inst_read = 1'b1;
      inst_addr = a;
      exp_q.push_back(mem_word(a));
      lat = -1;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (inst_resp === 1'b1) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      exp_word = exp_q.pop_front();
      check({tag, "_latency"}, lat, exp_lat);
      if (lat >= 0) check({tag, "_rdata"}, inst_rdata, exp_word);
   endtask

   task automatic go_idle();
      @(negedge clk);
      inst_read = 1'b0;
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int          f0;
      logic [31:0] h0;
      logic [31:0] m0;

      // Reset state
      @(negedge clk);
      #1;
      check("rst_inst_resp", inst_resp, 1'b0);
      check("rst_pmem_read", pmem_read, 1'b0);
      check("rst_pmem_address", pmem_address, 32'h0);
      check("rst_hit_count", hit_count, 32'h0);
      check("rst_miss_count", miss_count, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Cold miss
      fetch(32'h6000_0004, 4, "cold");
      go_idle();
      check("cold_fill_addr", last_fill, 32'h6000_0000);
      check("cold_miss_count", miss_count, 32'd1);
      check("cold_fills", n_fills, 32'd1);

      // Same-line back-to-back hits
      h0 = hit_count;
      f0 = n_fills;
      for (int i = 0; i < 8; i++) fetch(32'h6000_0000 + 32'(4 * i), 0, "line_hit");
      go_idle();
      check("line_hit_count", hit_count - h0, 32'd8);
      check("line_hit_no_fill", n_fills - f0, 32'd0);
      check("line_pmem_read", pmem_read, 1'b0);

      // Conflict misses on the same set
      pulse_reset();
      f0 = n_fills;
      fetch(32'h6000_0000, 4, "conf_a");
      fetch(32'h6000_0100, 4, "conf_b");
      fetch(32'h6000_0000, 4, "conf_a2");
      go_idle();
      check("conf_miss_count", miss_count, 32'd3);
      check("conf_fills", n_fills - f0, 32'd3);

      // Abandoned fill still installs the line
      h0 = hit_count;
      f0 = n_fills;
      @(negedge clk);
      inst_read = 1'b1;
      inst_addr = 32'h6000_0040;
      @(negedge clk);
      #1;
      check("aband_pmem_read", pmem_read, 1'b1);
      check("aband_pmem_address", pmem_address, 32'h6000_0040);
      inst_read = 1'b0;
      inst_addr = 32'h6000_0300;
      for (int c = 0; c < 20 && n_fills == f0; c++) @(negedge clk);
      @(negedge clk);
      #1;
      check("aband_fill_done", n_fills - f0, 32'd1);
      check("aband_no_resp", hit_count, h0);
      f0 = n_fills;
      fetch(32'h6000_0048, 0, "aband_hit");
      go_idle();
      check("aband_hit_no_fill", n_fills - f0, 32'd0);

      // Reset mid-fill
      @(negedge clk);
      inst_read = 1'b1;
      inst_addr = 32'h6000_0200;
      @(negedge clk);
      #1;
      check("midrst_pmem_read_before", pmem_read, 1'b1);
      #1;
      rst = 1'b0;
      inst_read = 1'b0;
      #1;
      check("midrst_pmem_read_async", pmem_read, 1'b0);
      check("midrst_miss_count", miss_count, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      f0 = n_fills;
      @(negedge clk);
      stray_resp = 1'b1;
      @(negedge clk);
      stray_resp = 1'b0;
      #1;
      check("stray_pmem_read", pmem_read, 1'b0);
      check("stray_miss_count", miss_count, 32'd0);
      fetch(32'h6000_0048, 4, "midrst_refetch");
      go_idle();
      check("midrst_refetch_miss", miss_count, 32'd1);
      check("midrst_refetch_fill", n_fills - f0, 32'd1);

      // Hit counter saturation
      m0 = miss_count;
      force dut.hit_count = 32'hFFFF_FFFE;
      #1;
      release dut.hit_count;
      for (int i = 0; i < 3; i++) fetch(32'h6000_0048, 0, "sat_hit");
      go_idle();
      check("sat_hit_count", hit_count, 32'hFFFF_FFFF);
      check("sat_miss_count", miss_count, m0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
